// File: rtl/booth_mult_ctrl.sv
// rtl/booth_mult_ctrl.sv - radix-2 Booth sequencer for a signed 32x32 multiply over one shared adder
// Contains the cla_32 and full_adder helpers used as the 33-bit add/subtract datapath.

module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module cla_32 (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        cin_i,
  output logic [31:0] sum_o,
  output logic        cout_o
);
  logic [31:0] g;
  logic [31:0] p;
  logic [32:0] c;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  // 4-bit lookahead groups; only the group carry-in ripples between groups
  always_comb begin
    c    = '0;
    c[0] = cin_i;
    for (int b = 0; b < 32; b += 4) begin
      c[b+1] = g[b] | (p[b] & c[b]);
      c[b+2] = g[b+1] | (p[b+1] & g[b]) | (p[b+1] & p[b] & c[b]);
      c[b+3] = g[b+2] | (p[b+2] & g[b+1]) | (p[b+2] & p[b+1] & g[b])
             | (p[b+2] & p[b+1] & p[b] & c[b]);
      c[b+4] = g[b+3] | (p[b+3] & g[b+2]) | (p[b+3] & p[b+2] & g[b+1])
             | (p[b+3] & p[b+2] & p[b+1] & g[b])
             | (p[b+3] & p[b+2] & p[b+1] & p[b] & c[b]);
    end
  end

  assign sum_o  = p ^ c[31:0];
  assign cout_o = c[32];
endmodule

module booth_mult_ctrl #(
  parameter int N_ITER = 32
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        start,
  input  logic        flush,
  input  logic [31:0] multiplicand,
  input  logic [31:0] multiplier,
  output logic        busy,
  output logic        result_ready,
  output logic [31:0] product,
  output logic        overflow
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [4:0] LAST_CNT = 5'(N_ITER - 1);

  state_t      state_q;
  logic [32:0] a_q;
  logic [31:0] qr_q;
  logic        q1_q;
  logic [31:0] mr_q;
  logic [4:0]  cnt_q;
  logic        busy_q;
  logic        result_ready_q;
  logic [31:0] product_q;
  logic        overflow_q;

  logic        do_sub;
  logic        do_op;
  logic [31:0] cla_b;
  logic [31:0] cla_sum;
  logic        cla_cout;
  logic        fa_sum;
  logic        fa_cout_unused;
  logic [32:0] a_new;
  logic [32:0] a_d;
  logic [31:0] qr_d;
  logic        q1_d;

  assign do_sub = qr_q[0] & ~q1_q;
  assign do_op  = qr_q[0] ^ q1_q;
  assign cla_b  = do_sub ? ~mr_q : mr_q;

  cla_32 u_cla (
    .a_i    (a_q[31:0]),
    .b_i    (cla_b),
    .cin_i  (do_sub),
    .sum_o  (cla_sum),
    .cout_o (cla_cout)
  );

  // Bit 32 carries the sign extension of Mr so M = 0x80000000 subtracts exactly
  full_adder u_fa32 (
    .a_i (a_q[32]),
    .b_i (cla_b[31]),
    .c_i (cla_cout),
    .s_o (fa_sum),
    .c_o (fa_cout_unused)
  );

  always_comb begin
    a_new = do_op ? {fa_sum, cla_sum} : a_q;
    a_d   = {a_new[32], a_new[32:1]};
    qr_d  = {a_new[0], qr_q[31:1]};
    q1_d  = qr_q[0];
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q        <= S_IDLE;
      a_q            <= '0;
      qr_q           <= '0;
      q1_q           <= 1'b0;
      mr_q           <= '0;
      cnt_q          <= '0;
      busy_q         <= 1'b0;
      result_ready_q <= 1'b0;
      product_q      <= '0;
      overflow_q     <= 1'b0;
    end else begin
      result_ready_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start && !flush) begin
            mr_q    <= multiplicand;
            qr_q    <= multiplier;
            a_q     <= '0;
            q1_q    <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          if (flush) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            a_q   <= a_d;
            qr_q  <= qr_d;
            q1_q  <= q1_d;
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == LAST_CNT) begin
              // Upper word must be pure sign extension of the low word to fit in 32 bits
              product_q      <= qr_d;
              overflow_q     <= (a_d[31:0] != {32{qr_d[31]}});
              result_ready_q <= 1'b1;
              state_q        <= S_DONE;
            end
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy         = busy_q;
  assign result_ready = result_ready_q;
  assign product      = product_q;
  assign overflow     = overflow_q;
endmodule

// File: tb/tb_booth_mult_ctrl.sv
// tb/tb_booth_mult_ctrl.sv - randomized self-checking bench for booth_mult_ctrl
// Expected products come from native 64-bit signed multiplication.

module tb_booth_mult_ctrl;
  logic        clock;
  logic        resetn;
  logic        start;
  logic        flush;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic        busy;
  logic        result_ready;
  logic [31:0] product;
  logic        overflow;

  int          n_checks;
  int          n_errors;
  logic [31:0] exp_prod;
  logic        exp_ovf;
  logic [31:0] corners [5];

  booth_mult_ctrl #(.N_ITER(32)) dut (
    .clock        (clock),
    .resetn       (resetn),
    .start        (start),
    .flush        (flush),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .result_ready (result_ready),
    .product      (product),
    .overflow     (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [32:0] ref_mult(input logic [31:0] m, input logic [31:0] q);
    longint      pr;
    logic [63:0] pv;
    logic        ovf;
    pr  = longint'($signed(m)) * longint'($signed(q));
    pv  = pr;
    ovf = (pr != longint'($signed(pv[31:0])));
    return {ovf, pv[31:0]};
  endfunction

  // Accept an operation, scramble the operand inputs, then follow it to completion
  task automatic run_op(input logic [31:0] m, input logic [31:0] q, input string tag);
    int   cyc;
    int   rr_cyc;
    int   rr_cnt;
    logic [32:0] r;
    multiplicand = m;
    multiplier   = q;
    start        = 1'b1;
    tick();
    start        = 1'b0;
    multiplicand = $urandom;
    multiplier   = $urandom;
    r        = ref_mult(m, q);
    exp_prod = r[31:0];
    exp_ovf  = r[32];
    cyc = 0;
    rr_cyc = 0;
    rr_cnt = 0;
    while (busy && cyc < 40) begin
      cyc++;
      if (result_ready) begin
        rr_cnt++;
        rr_cyc = cyc;
      end
      tick();
    end
    check({tag, "_busy_cycles"}, 64'(cyc), 64'd33);
    check({tag, "_rr_cycle"}, 64'(rr_cyc), 64'd33);
    check({tag, "_rr_pulses"}, 64'(rr_cnt), 64'd1);
    check({tag, "_product"}, 64'(product), 64'(exp_prod));
    check({tag, "_overflow"}, 64'(overflow), 64'(exp_ovf));
  endtask

  initial begin
    int          rr_seen;
    int          rc;
    logic [31:0] m;
    logic [31:0] q;
    logic [32:0] r;

    n_checks = 0;
    n_errors = 0;
    corners[0] = 32'h0000_0000;
    corners[1] = 32'h0000_0001;
    corners[2] = 32'hFFFF_FFFF;
    corners[3] = 32'h8000_0000;
    corners[4] = 32'h7FFF_FFFF;
    resetn = 1'b0;
    start = 1'b0;
    flush = 1'b0;
    multiplicand = '0;
    multiplier = '0;
    exp_prod = '0;
    exp_ovf = 1'b0;

    tick();
    tick();
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_rr", 64'(result_ready), 64'd0);
    check("reset_product", 64'(product), 64'd0);
    check("reset_overflow", 64'(overflow), 64'd0);
    resetn = 1'b1;
    tick();

    run_op(32'd3, 32'd5, "mul_3x5");
    check("const_3x5", 64'(product), 64'h0000_000F);
    run_op(-32'sd7, 32'd6, "mul_m7x6");
    check("const_m7x6", 64'(product), 64'hFFFF_FFD6);
    run_op(32'd0, 32'h1234_5678, "mul_zero");
    run_op(32'h7FFF_FFFF, 32'd2, "mul_max_x2");
    check("const_max_x2_ovf", 64'(overflow), 64'd1);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, "mul_min_xm1");
    run_op(32'h8000_0000, 32'h8000_0000, "mul_min_xmin");
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul_m1xm1");

    for (int i = 0; i < 20; i++) begin
      m = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
      q = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
      if ($urandom_range(0, 1) == 1) begin
        m = $signed(m) >>> $urandom_range(8, 24);
        q = $signed(q) >>> $urandom_range(8, 24);
      end
      run_op(m, q, $sformatf("rand%0d", i));
    end

    // Ignored start mid-run, then flush at RUN cycle 20
    run_op(32'd3, 32'd5, "pre_flush");
    multiplicand = 32'd4;
    multiplier   = 32'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    rr_seen = 0;
    for (rc = 1; rc <= 20; rc++) begin
      if (result_ready) rr_seen++;
      if (rc == 10) begin
        multiplicand = 32'd9;
        multiplier   = 32'd9;
        start        = 1'b1;
      end
      if (rc == 20) flush = 1'b1;
      tick();
      start = 1'b0;
      flush = 1'b0;
      if (rc == 19) check("flush_busy_before", 64'(busy), 64'd1);
    end
    check("flush_busy_after", 64'(busy), 64'd0);
    for (int i = 0; i < 40; i++) begin
      if (result_ready || busy) rr_seen++;
      tick();
    end
    check("flush_no_activity", 64'(rr_seen), 64'd0);
    check("flush_product_held", 64'(product), 64'd15);
    check("flush_overflow_held", 64'(overflow), 64'd0);

    // Flush on the final RUN cycle must suppress the result
    multiplicand = 32'd100;
    multiplier   = 32'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    rr_seen = 0;
    for (rc = 1; rc <= 32; rc++) begin
      if (result_ready) rr_seen++;
      if (rc == 32) flush = 1'b1;
      tick();
      flush = 1'b0;
    end
    for (int i = 0; i < 5; i++) begin
      if (result_ready || busy) rr_seen++;
      tick();
    end
    check("lastcyc_flush_none", 64'(rr_seen), 64'd0);
    check("lastcyc_flush_product", 64'(product), 64'd15);

    // start together with flush in IDLE
    multiplicand = 32'd11;
    multiplier   = 32'd11;
    start = 1'b1;
    flush = 1'b1;
    tick();
    start = 1'b0;
    flush = 1'b0;
    check("start_flush_busy", 64'(busy), 64'd0);
    tick();
    check("start_flush_busy2", 64'(busy), 64'd0);

    // start in DONE ignored, start the following cycle accepted
    multiplicand = 32'd2;
    multiplier   = 32'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    rc = 0;
    while (!result_ready && rc < 40) begin
      rc++;
      tick();
    end
    check("done_rr_seen", 64'(result_ready), 64'd1);
    check("done_product", 64'(product), 64'd14);
    multiplicand = 32'd5;
    multiplier   = 32'd5;
    start = 1'b1;
    tick();
    check("done_start_ignored", 64'(busy), 64'd0);
    tick();
    start = 1'b0;
    check("after_done_accepted", 64'(busy), 64'd1);
    rc = 0;
    while (!result_ready && rc < 40) begin
      rc++;
      tick();
    end
    r = ref_mult(32'd5, 32'd5);
    check("after_done_product", 64'(product), 64'(r[31:0]));
    tick();

    // Asynchronous reset in the middle of RUN cycle 17
    run_op(32'h7FFF_FFFF, 32'd2, "pre_reset");
    multiplicand = 32'd4;
    multiplier   = 32'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (rc = 1; rc < 17; rc++) tick();
    #2;
    resetn = 1'b0;
    #2;
    check("mid_reset_busy", 64'(busy), 64'd0);
    check("mid_reset_product", 64'(product), 64'd0);
    check("mid_reset_overflow", 64'(overflow), 64'd0);
    check("mid_reset_rr", 64'(result_ready), 64'd0);
    #3;
    resetn = 1'b1;
    tick();
    rr_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (result_ready || busy) rr_seen++;
      tick();
    end
    check("post_reset_quiet", 64'(rr_seen), 64'd0);
    run_op(32'd2, 32'd3, "post_reset_2x3");
    check("post_reset_const", 64'(product), 64'd6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "watchdog");
  end
endmodule
